// File: rtl/dm_responder_pkg.sv
// Shared codes for the data-memory responder: access-size codes, FSM states
// and the load-extension helpers used by the lane logic.
package dm_responder_pkg;

  localparam logic [1:0] MEM_W = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sext);
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    h_s = signed'(h);
    w_s = h_s;
    return sext ? unsigned'(w_s) : {16'h0000, h};
  endfunction

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sext);
    logic signed [7:0]  b_s;
    logic signed [31:0] w_s;
    b_s = signed'(b);
    w_s = b_s;
    return sext ? unsigned'(w_s) : {24'h000000, b};
  endfunction

endpackage

// File: rtl/dm_responder_lane.sv
// dm_lane: combinational byte-lane steering for one access -- byte enables,
// replicated store data, extended load data and the misalignment flag.
module dm_lane
  import dm_responder_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        sext,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
  assign byte_sel = rword[{addr_lo, 3'b000} +: 8];

  // Reserved mode falls through to word behaviour; it is flagged so the
  // parent can reject it when alignment checking is built in.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rword;
    misalign  = 1'b1;
    case (mode)
      MEM_W: begin
        misalign = |addr_lo;
      end
      MEM_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {wdata[15:0], wdata[15:0]};
        rdata_ext = ext_half(half_sel, sext);
        misalign  = addr_lo[0];
      end
      MEM_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = ext_byte(byte_sel, sext);
        misalign  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: M-stage data-memory model with programmable wait states.
// Optional alignment checking is built in when DM_ALIGN_CHECK_EN is defined.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_mode,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

`ifdef DM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          mode_q, mode_d;
  logic                sext_q, sext_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic                in_idle;
  logic                op_we;
  logic [1:0]          op_mode;
  logic                op_sext;
  logic [ADDR_W+1:0]   op_addr;
  logic [31:0]         op_wdata;
  logic [ADDR_W-1:0]   op_idx;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wdata_rep;
  logic [31:0]         rdata_ext;
  logic                misalign;
  logic                rej;
  logic                enter_resp;
  logic                wr_en;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign in_idle = (state_q == IDLE);
  assign accept  = req_valid && req_ready;

  // With zero wait states the access commits on the accept edge itself, so
  // the lane logic must look at the live request rather than the latched one.
  assign op_we    = in_idle ? req_we                 : we_q;
  assign op_mode  = in_idle ? req_mode               : mode_q;
  assign op_sext  = in_idle ? req_sext               : sext_q;
  assign op_addr  = in_idle ? req_addr[ADDR_W+1:0]   : addr_q;
  assign op_wdata = in_idle ? req_wdata              : wdata_q;
  assign op_idx   = op_addr[ADDR_W+1:2];
  assign rword    = mem_q[op_idx];

  dm_lane u_lane (
    .mode      (op_mode),
    .addr_lo   (op_addr[1:0]),
    .wdata     (op_wdata),
    .rword     (rword),
    .sext      (op_sext),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign rej        = ALIGN_CHECK && misalign;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign wr_en      = enter_resp && op_we && !rej;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = reset && in_idle;
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = ALIGN_CHECK && err_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (op_we || rej) ? 32'h0 : rdata_ext;
      err_d   = rej;
    end
  end

  always_comb begin
    we_d    = we_q;
    mode_d  = mode_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      we_d    = req_we;
      mode_d  = req_mode;
      sext_d  = req_sext;
      addr_d  = req_addr[ADDR_W+1:0];
      wdata_d = req_wdata;
    end
  end

  // ---- request capture stage: data-only, no reset ----
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    mode_q  <= mode_d;
    sext_q  <= sext_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // ---- array commit stage: reset clears every word ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[op_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: two instances (one wait state and zero wait
// states) checked against a scoreboard of expected responses.
module tb_dm_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, req_we, req_sext;
  logic [1:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_we0, req_sext0;
  logic [1:0]  req_mode0;
  logic [31:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  int   vectors;
  int   miscompares;
  int   cyc;
  int   resp_cnt1;
  int   resp_cnt0;
  exp_t sb1[$];
  exp_t sb0[$];

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_mode   (req_mode),
    .req_sext   (req_sext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid0),
    .req_ready  (req_ready0),
    .req_we     (req_we0),
    .req_mode   (req_mode0),
    .req_sext   (req_sext0),
    .req_addr   (req_addr0),
    .req_wdata  (req_wdata0),
    .resp_valid (resp_valid0),
    .resp_rdata (resp_rdata0),
    .resp_err   (resp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input bit use0, input logic [31:0] rd, input logic er);
    exp_t e;
    vectors++;
    assert ((use0 ? sb0.size() : sb1.size()) != 0) else begin
      miscompares++;
      $error("FAIL spurious_resp%0d: got a response, expected none", use0 ? 0 : 1);
    end
    if ((use0 ? sb0.size() : sb1.size()) != 0) begin
      e = use0 ? sb0.pop_front() : sb1.pop_front();
      chk({e.tag, "_rdata"}, rd, e.rdata);
      chk({e.tag, "_err"}, 32'(er), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      resp_cnt1++;
      pop_check(1'b0, resp_rdata, resp_err);
    end
    if (resp_valid0 === 1'b1) begin
      resp_cnt0++;
      pop_check(1'b1, resp_rdata0, resp_err0);
    end
  end

  task automatic push_exp(input bit use0, input logic [31:0] rd, input logic er, input string tag);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.tag   = tag;
    if (use0) sb0.push_back(e);
    else      sb1.push_back(e);
  endtask

  task automatic drive(input bit use0, input logic v, input logic we, input logic [1:0] mode,
                       input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
    if (use0) begin
      req_valid0 = v; req_we0 = we; req_mode0 = mode;
      req_sext0 = sext; req_addr0 = addr; req_wdata0 = wdata;
    end else begin
      req_valid = v; req_we = we; req_mode = mode;
      req_sext = sext; req_addr = addr; req_wdata = wdata;
    end
  endtask

  // Single request on the one-wait-state instance with latency and pulse-width checks.
  task automatic req1(input logic we, input logic [1:0] mode, input logic sext,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int k;
    int lat;
    @(negedge clk);
    drive(1'b0, 1'b1, we, mode, sext, addr, wdata);
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    push_exp(1'b0, exp_rd, exp_err, tag);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  // Three requests with req_valid held high; checks accept spacing.
  task automatic burst(input bit use0, input logic we, input logic [31:0] base,
                       input logic [31:0] seed, input string tag);
    int acc[3];
    int k;
    int gap;
    @(negedge clk);
    drive(use0, 1'b1, we, 2'd0, 1'b0, base, seed);
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while ((use0 ? req_ready0 : req_ready) !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      push_exp(use0, we ? 32'h0 : seed + 32'(i), 1'b0, $sformatf("%s%0d", tag, i));
      @(posedge clk);
      @(negedge clk);
      acc[i] = cyc;
      if (i < 2) drive(use0, 1'b1, we, 2'd0, 1'b0, base + 32'(4 * (i + 1)), seed + 32'(i + 1));
      else       drive(use0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    end
    gap = use0 ? 2 : 3;
    chk({tag, "_gap01"}, 32'(acc[1] - acc[0]), 32'(gap));
    chk({tag, "_gap12"}, 32'(acc[2] - acc[1]), 32'(gap));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int rc1;
    int rc0;
    vectors     = 0;
    miscompares = 0;
    resp_cnt1   = 0;
    resp_cnt0   = 0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);

    req1(1'b1, 2'd0, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, "st_w10");
    req1(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, "ld_w10");

    req1(1'b1, 2'd2, 1'b0, 32'h13, 32'hFFFFFFAB, 32'h0, 1'b0, "st_b13");
    req1(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hAB345678, 1'b0, "ld_w10_b");
    req1(1'b0, 2'd2, 1'b1, 32'h13, 32'h0, 32'hFFFFFFAB, 1'b0, "ld_b13_s");
    req1(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h000000AB, 1'b0, "ld_b13_z");
    req1(1'b0, 2'd2, 1'b1, 32'h11, 32'h0, 32'h00000056, 1'b0, "ld_b11_s");

    req1(1'b1, 2'd1, 1'b0, 32'h22, 32'hCDEF8001, 32'h0, 1'b0, "st_h22");
    req1(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 32'h80010000, 1'b0, "ld_w20");
    req1(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, "ld_h22_s");
    req1(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h00008001, 1'b0, "ld_h22_z");
    req1(1'b0, 2'd2, 1'b1, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, "ld_b23_s");
    req1(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'h00000000, 1'b0, "ld_h20_s");

    req1(1'b1, 2'd0, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, "st_w10_again");
    req1(1'b0, 2'd0, 1'b0, 32'h4010, 32'h0, 32'h12345678, 1'b0, "ld_wrap");
`ifdef DM_ALIGN_CHECK_EN
    req1(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "ld_w11_mis");
    req1(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1, "st_w11_mis");
    req1(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, "ld_w10_kept");
    req1(1'b0, 2'd1, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1, "ld_h23_mis");
    req1(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, "ld_mode3");
`else
    req1(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h12345678, 1'b0, "ld_w11_mis");
    req1(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b0, "st_w11_mis");
    req1(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0, "ld_w10_over");
    req1(1'b0, 2'd1, 1'b0, 32'h23, 32'h0, 32'h00008001, 1'b0, "ld_h23_mis");
    req1(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h80010000, 1'b0, "ld_mode3");
`endif

    rc1 = resp_cnt1;
    burst(1'b0, 1'b1, 32'h100, 32'hA5A50000, "b2b1_st");
    chk("b2b1_st_count", 32'(resp_cnt1 - rc1), 32'd3);
    rc1 = resp_cnt1;
    burst(1'b0, 1'b0, 32'h100, 32'hA5A50000, "b2b1_ld");
    chk("b2b1_ld_count", 32'(resp_cnt1 - rc1), 32'd3);

    rc0 = resp_cnt0;
    burst(1'b1, 1'b1, 32'h200, 32'h5A5A0010, "b2b0_st");
    chk("b2b0_st_count", 32'(resp_cnt0 - rc0), 32'd3);
    rc0 = resp_cnt0;
    burst(1'b1, 1'b0, 32'h200, 32'h5A5A0010, "b2b0_ld");
    chk("b2b0_ld_count", 32'(resp_cnt0 - rc0), 32'd3);

    rc1 = resp_cnt1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 32'hDEADBEEF);
    chk("rmid_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("rmid_ready_low", 32'(req_ready), 32'd0);
    chk("rmid_no_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("rmid_ready_low2", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rmid_ready_rel", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rmid_no_resp", 32'(resp_cnt1 - rc1), 32'd0);
    req1(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, "ld_w40_after_rst");
    req1(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "ld_w10_cleared");

    repeat (3) @(negedge clk);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
